// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables/flushes, dmem timeout FSM, halt.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_raw_stall,
    input  logic        i_ex_redirect,
    input  logic        i_imem_ready,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ready,
    input  logic        i_wb_halt,
    output logic        o_pc_en,
    output logic        o_if_id_en,
    output logic        o_id_ex_en,
    output logic        o_ex_mem_en,
    output logic        o_mem_wb_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic        o_mem_wb_flush,
    output logic        o_halted,
    output logic        o_fault,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_redirects
);

    localparam int CW = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'(DMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        FLUSH    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t        state, next_state;
    logic [CW-1:0] wait_count;
    logic          fault;
    logic          run_eval;
    logic          wait_expired;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= FLUSH;
            wait_count <= '0;
            fault      <= 1'b0;
        end else begin
            state <= next_state;
            if (state == MEM_WAIT && !i_dmem_ready && !wait_expired)
                wait_count <= wait_count + 1'b1;
            else
                wait_count <= '0;
            if (wait_expired)
                fault <= 1'b1;
        end
    end

    // run_eval marks cycles where the normal RUN priority rules drive the stages,
    // including the MEM_WAIT cycle in which data memory finally answers.
    always_comb begin
        next_state     = state;
        run_eval       = 1'b0;
        wait_expired   = 1'b0;
        o_pc_en        = 1'b0;
        o_if_id_en     = 1'b0;
        o_id_ex_en     = 1'b0;
        o_ex_mem_en    = 1'b0;
        o_mem_wb_en    = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_mem_wb_flush = 1'b0;

        case (state)
            FLUSH: begin
                o_if_id_flush  = 1'b1;
                o_id_ex_flush  = 1'b1;
                o_ex_mem_flush = 1'b1;
                o_mem_wb_flush = 1'b1;
                next_state     = RUN;
            end
            RUN: begin
                if (i_dmem_req && !i_dmem_ready)
                    next_state = MEM_WAIT;
                else
                    run_eval = 1'b1;
            end
            MEM_WAIT: begin
                if (i_dmem_ready) begin
                    run_eval = 1'b1;
                end else if (wait_count == WAIT_LAST) begin
                    wait_expired = 1'b1;
                    next_state   = HALT;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: next_state = FLUSH;
        endcase

        if (run_eval) begin
            if (i_wb_halt) begin
                next_state = HALT;
            end else begin
                next_state = RUN;
                if (i_ex_redirect) begin
                    o_pc_en       = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    o_ex_mem_en   = 1'b1;
                    o_mem_wb_en   = 1'b1;
                end else if (i_raw_stall) begin
                    o_id_ex_flush = 1'b1;
                    o_ex_mem_en   = 1'b1;
                    o_mem_wb_en   = 1'b1;
                end else if (!i_imem_ready) begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_en    = 1'b1;
                    o_ex_mem_en   = 1'b1;
                    o_mem_wb_en   = 1'b1;
                end else begin
                    o_pc_en     = 1'b1;
                    o_if_id_en  = 1'b1;
                    o_id_ex_en  = 1'b1;
                    o_ex_mem_en = 1'b1;
                    o_mem_wb_en = 1'b1;
                end
            end
        end
    end

    assign o_halted = (state == HALT);
    assign o_fault  = fault;
    assign o_state  = state;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] redirect_count;
    logic        redirect_taken;

    assign redirect_taken = run_eval && !i_wb_halt && i_ex_redirect;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_count    <= '0;
            redirect_count <= '0;
        end else begin
            if ((state == RUN || state == MEM_WAIT) && !o_pc_en)
                stall_count <= stall_count + 32'd1;
            if (redirect_taken)
                redirect_count <= redirect_count + 32'd1;
        end
    end

    assign o_stall_cycles = stall_count;
    assign o_redirects    = redirect_count;
`else
    assign o_stall_cycles = 32'd0;
    assign o_redirects    = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, corner sequences, random vs. model.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic rst_n;
        logic raw;
        logic redir;
        logic imem;
        logic dreq;
        logic drdy;
        logic halt;
    } in_t;

    typedef struct packed {
        logic [4:0] en;
        logic [3:0] fl;
        logic       halted;
        logic       fault;
        logic [1:0] st;
    } outs_t;

    typedef struct packed {
        in_t   in;
        outs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, raw_stall, ex_redirect, imem_ready, dmem_req, dmem_ready, wb_halt;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        halted, fault;
    logic [1:0]  state;
    logic [31:0] stall_cycles, redirects;
    logic [12:0] dut_outs;

    int checks = 0;
    int passes = 0;

    int          m_mode;
    int          m_wait;
    bit          m_fault;
    logic [31:0] m_stall;
    logic [31:0] m_redir;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DMEM_TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_raw_stall    (raw_stall),
        .i_ex_redirect  (ex_redirect),
        .i_imem_ready   (imem_ready),
        .i_dmem_req     (dmem_req),
        .i_dmem_ready   (dmem_ready),
        .i_wb_halt      (wb_halt),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_id_ex_en     (id_ex_en),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_en    (mem_wb_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_flush  (id_ex_flush),
        .o_ex_mem_flush (ex_mem_flush),
        .o_mem_wb_flush (mem_wb_flush),
        .o_halted       (halted),
        .o_fault        (fault),
        .o_state        (state),
        .o_stall_cycles (stall_cycles),
        .o_redirects    (redirects)
    );

    assign dut_outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                       halted, fault, state};

    task automatic applyStimulus(input in_t v);
        rst_n       = v.rst_n;
        raw_stall   = v.raw;
        ex_redirect = v.redir;
        imem_ready  = v.imem;
        dmem_req    = v.dreq;
        dmem_ready  = v.drdy;
        wb_halt     = v.halt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: mode 0..3 = flush/run/wait/halt, described by the stage rules.
    function automatic outs_t modelOut(input int mode, input bit flt, input in_t v);
        outs_t o;
        bit    evr;
        o        = '0;
        o.st     = 2'(mode);
        o.fault  = flt;
        o.halted = (mode == 3);
        evr = (mode == 1 && !(v.dreq && !v.drdy)) || (mode == 2 && v.drdy);
        if (mode == 0) begin
            o.fl = 4'b1111;
        end else if (evr && !v.halt) begin
            if (v.redir) begin
                o.en = 5'b10011;
                o.fl = 4'b1100;
            end else if (v.raw) begin
                o.en = 5'b00011;
                o.fl = 4'b0100;
            end else if (!v.imem) begin
                o.en = 5'b00111;
                o.fl = 4'b1000;
            end else begin
                o.en = 5'b11111;
            end
        end
        return o;
    endfunction

    task automatic modelStep(input in_t v);
        outs_t o;
        bit    evr;
        o = modelOut(m_mode, m_fault, v);
        if (!v.rst_n) begin
            m_mode  = 0;
            m_wait  = 0;
            m_fault = 1'b0;
            m_stall = '0;
            m_redir = '0;
            return;
        end
        evr = (m_mode == 1 && !(v.dreq && !v.drdy)) || (m_mode == 2 && v.drdy);
        if ((m_mode == 1 || m_mode == 2) && !o.en[4])
            m_stall = m_stall + 32'd1;
        if (evr && !v.halt && v.redir)
            m_redir = m_redir + 32'd1;
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (v.dreq && !v.drdy) begin
                    m_mode = 2;
                    m_wait = 0;
                end else if (v.halt) begin
                    m_mode = 3;
                end
            end
            2: begin
                if (v.drdy) begin
                    m_mode = v.halt ? 3 : 1;
                end else begin
                    m_wait++;
                    if (m_wait >= TIMEOUT) begin
                        m_mode  = 3;
                        m_fault = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic doReset();
        applyStimulus(7'b0001000);
        tick();
        tick();
        applyStimulus(7'b1001000);
        m_mode  = 0;
        m_wait  = 0;
        m_fault = 1'b0;
        m_stall = '0;
        m_redir = '0;
    endtask

    vec_t vecs[$];

    initial begin
        int waits;
        int guard;
        in_t r;
        outs_t e;

        // Rows: {rst_n,raw,redir,imem,dreq,drdy,halt} ; {en[pc..memwb], fl[ifid..memwb], halted, fault, state}
        vecs.push_back('{in: 7'b1001000, exp: 13'b00000_1111_0_0_00});
        vecs.push_back('{in: 7'b1001000, exp: 13'b11111_0000_0_0_01});
        vecs.push_back('{in: 7'b1101000, exp: 13'b00011_0100_0_0_01});
        vecs.push_back('{in: 7'b1101000, exp: 13'b00011_0100_0_0_01});
        vecs.push_back('{in: 7'b1001000, exp: 13'b11111_0000_0_0_01});
        vecs.push_back('{in: 7'b1111000, exp: 13'b10011_1100_0_0_01});
        vecs.push_back('{in: 7'b1000000, exp: 13'b00111_1000_0_0_01});
        vecs.push_back('{in: 7'b1001100, exp: 13'b00000_0000_0_0_01});
        vecs.push_back('{in: 7'b1001100, exp: 13'b00000_0000_0_0_10});
        vecs.push_back('{in: 7'b1001100, exp: 13'b00000_0000_0_0_10});
        vecs.push_back('{in: 7'b1001110, exp: 13'b11111_0000_0_0_10});
        vecs.push_back('{in: 7'b1001000, exp: 13'b11111_0000_0_0_01});
        vecs.push_back('{in: 7'b1001101, exp: 13'b00000_0000_0_0_01});
        vecs.push_back('{in: 7'b1001111, exp: 13'b00000_0000_0_0_10});
        vecs.push_back('{in: 7'b1001000, exp: 13'b00000_0000_1_0_11});
        vecs.push_back('{in: 7'b1011000, exp: 13'b00000_0000_1_0_11});
        vecs.push_back('{in: 7'b0001000, exp: 13'b00000_0000_1_0_11});
        vecs.push_back('{in: 7'b1001000, exp: 13'b00000_1111_0_0_00});
        vecs.push_back('{in: 7'b1001000, exp: 13'b11111_0000_0_0_01});
        vecs.push_back('{in: 7'b1011100, exp: 13'b00000_0000_0_0_01});
        vecs.push_back('{in: 7'b1011100, exp: 13'b00000_0000_0_0_10});
        vecs.push_back('{in: 7'b1011110, exp: 13'b10011_1100_0_0_10});
        vecs.push_back('{in: 7'b0000000, exp: 13'b00111_1000_0_0_01});
        vecs.push_back('{in: 7'b1001000, exp: 13'b00000_1111_0_0_00});

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].in);
            @(negedge clk);
            checkOutput($sformatf("vec%0d", i), 32'(dut_outs), 32'(vecs[i].exp));
            tick();
        end

        // Perf counters: two RAW stall cycles, then one redirect masking a RAW stall.
        doReset();
        applyStimulus(7'b1001000); tick();
        applyStimulus(7'b1101000); tick();
        applyStimulus(7'b1101000); tick();
        applyStimulus(7'b1001000);
        @(negedge clk);
        checkOutput("perf_stall", stall_cycles, PERF_ON ? 32'd2 : 32'd0);
        tick();
        applyStimulus(7'b1111000); tick();
        applyStimulus(7'b1001000);
        @(negedge clk);
        checkOutput("perf_redirect", redirects, PERF_ON ? 32'd1 : 32'd0);
        checkOutput("perf_stall_after_redirect", stall_cycles, PERF_ON ? 32'd2 : 32'd0);
        tick();

        // Timeout: memory never answers; count MEM_WAIT cycles before HALT.
        doReset();
        applyStimulus(7'b1001000); tick();
        applyStimulus(7'b1001100); tick();
        waits = 0;
        guard = 0;
        @(negedge clk);
        while (state != 2'd3 && guard < 20) begin
            if (state == 2'd2) waits++;
            guard++;
            tick();
            @(negedge clk);
        end
        checkOutput("timeout_wait_cycles", 32'(waits), 32'(TIMEOUT));
        checkOutput("timeout_state", 32'(state), 32'd3);
        checkOutput("timeout_fault", 32'(fault), 32'd1);
        checkOutput("timeout_halted", 32'(halted), 32'd1);
        applyStimulus(7'b0001000); tick();
        applyStimulus(7'b1001000);
        @(negedge clk);
        checkOutput("halt_reset_state", 32'(state), 32'd0);
        checkOutput("halt_reset_fault", 32'(fault), 32'd0);
        tick();

        // Ready arriving on the limit cycle wins over the timeout.
        doReset();
        applyStimulus(7'b1001000); tick();
        applyStimulus(7'b1001100); tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        applyStimulus(7'b1001110); tick();
        applyStimulus(7'b1001000);
        @(negedge clk);
        checkOutput("ready_wins_state", 32'(state), 32'd1);
        checkOutput("ready_wins_fault", 32'(fault), 32'd0);
        tick();

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            r.rst_n = ($urandom_range(0, 49) != 0);
            r.raw   = ($urandom_range(0, 3) == 0);
            r.redir = ($urandom_range(0, 4) == 0);
            r.imem  = ($urandom_range(0, 3) != 0);
            r.dreq  = ($urandom_range(0, 2) == 0);
            r.drdy  = ($urandom_range(0, 1) == 0);
            r.halt  = ($urandom_range(0, 39) == 0);
            applyStimulus(r);
            @(negedge clk);
            e = modelOut(m_mode, m_fault, r);
            checkOutput("rand_outs", 32'(dut_outs), 32'(e));
            checkOutput("rand_stall_cycles", stall_cycles, PERF_ON ? m_stall : 32'd0);
            checkOutput("rand_redirects", redirects, PERF_ON ? m_redir : 32'd0);
            @(posedge clk);
            modelStep(r);
            #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
